// File: rtl/corelet_ctrl.sv
// rtl/corelet_ctrl.sv - corelet tile sequencer; optional ACCUM pass enabled by CORELET_CTRL_ACCUM_EN
module corelet_ctrl #(
   parameter int row  = 8,
   parameter int col  = 8,
   parameter int nkij = 9,
   parameter int nact = 36
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        relu_en,
   input  logic        o_valid,
   input  logic        o_ready,
   output logic [8:0]  inst,
   output logic [10:0] xmem_addr,
   output logic        xmem_cen,
   output logic [10:0] pmem_addr,
   output logic        pmem_wen,
   output logic        pmem_cen,
   output logic        busy,
   output logic        done
);

   localparam logic [15:0] ROW_C  = 16'(row);
   localparam logic [15:0] COL_C  = 16'(col);
   localparam logic [15:0] NKIJ_C = 16'(nkij);
   localparam logic [15:0] NACT_C = 16'(nact);

   // inst bit positions
   localparam int KERNEL_LOAD = 0;
   localparam int EXECUTE     = 1;
   localparam int L0_WR       = 2;
   localparam int L0_RD       = 3;
   localparam int OFIFO_RD    = 6;
   localparam int SFP_SEL     = 7;
   localparam int RELU        = 8;

   typedef enum logic [3:0] {
      S_IDLE, S_W_LOAD, S_K_LOAD, S_K_WAIT, S_A_LOAD, S_EXEC, S_DRAIN, S_ACCUM, S_DONE
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_cnt, w_cnt_nxt;   // per-state step counter (output index o in ACCUM)
   logic [15:0] r_sub, w_sub_nxt;   // kernel index k inside ACCUM
   logic [15:0] r_kij, w_kij_nxt;   // kernel position of the current pass
   logic        r_relu, w_relu_nxt;

   // state and counter registers; reset aborts any tile in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_sub   <= '0;
         r_kij   <= '0;
         r_relu  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sub   <= w_sub_nxt;
         r_kij   <= w_kij_nxt;
         r_relu  <= w_relu_nxt;
      end
   end

   // next-state and instruction/SRAM control decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sub_nxt   = r_sub;
      w_kij_nxt   = r_kij;
      w_relu_nxt  = r_relu;
      inst        = '0;
      xmem_addr   = '0;
      xmem_cen    = 1'b1;
      pmem_addr   = '0;
      pmem_wen    = 1'b1;
      pmem_cen    = 1'b1;
      done        = 1'b0;
      busy        = (r_state != S_IDLE);
      inst[RELU]  = busy && r_relu;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_W_LOAD;
               w_cnt_nxt   = '0;
               w_kij_nxt   = '0;
               w_relu_nxt  = relu_en;
            end
         end
         // row weight reads; each L0 write trails its SRAM read by one cycle
         S_W_LOAD: begin
            if (r_cnt < ROW_C) begin
               xmem_cen  = 1'b0;
               xmem_addr = 11'(NACT_C + r_kij * ROW_C + r_cnt);
            end
            if (r_cnt != 16'd0) inst[L0_WR] = 1'b1;
            if (r_cnt == ROW_C) begin
               w_state_nxt = S_K_LOAD;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         S_K_LOAD: begin
            inst[L0_RD]       = 1'b1;
            inst[KERNEL_LOAD] = 1'b1;
            if (r_cnt == ROW_C - 16'd1) begin
               w_state_nxt = S_K_WAIT;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         // let the weights ripple across the columns
         S_K_WAIT: begin
            if (r_cnt == COL_C - 16'd1) begin
               w_state_nxt = S_A_LOAD;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         // activation reads, then hold idle (count parked past nact) until OFIFO has room
         S_A_LOAD: begin
            if (r_cnt < NACT_C) begin
               xmem_cen  = 1'b0;
               xmem_addr = 11'(r_cnt);
            end
            if (r_cnt != 16'd0 && r_cnt <= NACT_C) inst[L0_WR] = 1'b1;
            if (r_cnt >= NACT_C) begin
               if (o_ready) begin
                  w_state_nxt = S_EXEC;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = NACT_C + 16'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         S_EXEC: begin
            inst[L0_RD]   = 1'b1;
            inst[EXECUTE] = 1'b1;
            if (r_cnt == NACT_C - 16'd1) begin
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         // move one OFIFO row into psum SRAM per cycle that a row is available
         S_DRAIN: begin
            if (o_valid) begin
               inst[OFIFO_RD] = 1'b1;
               pmem_cen       = 1'b0;
               pmem_wen       = 1'b0;
               pmem_addr      = 11'(r_kij * NACT_C + r_cnt);
               if (r_cnt == NACT_C - 16'd1) begin
                  w_cnt_nxt = '0;
                  if (r_kij == NKIJ_C - 16'd1) begin
`ifdef CORELET_CTRL_ACCUM_EN
                     w_state_nxt = S_ACCUM;
                     w_sub_nxt   = '0;
`else
                     w_state_nxt = S_DONE;
`endif
                  end else begin
                     w_kij_nxt   = r_kij + 16'd1;
                     w_state_nxt = S_W_LOAD;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 16'd1;
               end
            end
         end
`ifdef CORELET_CTRL_ACCUM_EN
         // per output: stream nkij partial sums into the SFP, then write the total
         S_ACCUM: begin
            inst[SFP_SEL] = 1'b1;
            pmem_cen      = 1'b0;
            if (r_sub < NKIJ_C) begin
               pmem_addr = 11'(r_sub * NACT_C + r_cnt);
               w_sub_nxt = r_sub + 16'd1;
            end else begin
               pmem_wen  = 1'b0;
               pmem_addr = 11'(NKIJ_C * NACT_C + r_cnt);
               w_sub_nxt = '0;
               if (r_cnt == NACT_C - 16'd1) begin
                  w_state_nxt = S_DONE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 16'd1;
               end
            end
         end
`endif
         S_DONE: begin
            done        = 1'b1;
            w_kij_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb/tb_corelet_ctrl.sv - self-checking bench for corelet_ctrl against a trace-level reference model
`timescale 1ns/1ps
module tb_corelet_ctrl;

   localparam int ROW  = 8;
   localparam int COL  = 8;
   localparam int NKIJ = 9;
   localparam int NACT = 36;
   localparam int PER_KIJ = (ROW + 1) + ROW + COL + (NACT + 1) + NACT + NACT;
`ifdef CORELET_CTRL_ACCUM_EN
   localparam int TILE_LEN = NKIJ * PER_KIJ + NACT * (NKIJ + 1);
`else
   localparam int TILE_LEN = NKIJ * PER_KIJ;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        relu_en = 1'b0;
   logic        o_valid = 1'b1;
   logic        o_ready = 1'b1;
   logic [8:0]  inst;
   logic [10:0] xmem_addr;
   logic        xmem_cen;
   logic [10:0] pmem_addr;
   logic        pmem_wen;
   logic        pmem_cen;
   logic        busy;
   logic        done;

   corelet_ctrl #(.row(ROW), .col(COL), .nkij(NKIJ), .nact(NACT)) dut (
      .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
      .o_valid(o_valid), .o_ready(o_ready), .inst(inst),
      .xmem_addr(xmem_addr), .xmem_cen(xmem_cen),
      .pmem_addr(pmem_addr), .pmem_wen(pmem_wen), .pmem_cen(pmem_cen),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int ov_mode = 0;     // 0: o_valid held high, 1: toggles every cycle, 2: random
   logic exp_relu = 1'b0;

   int xq[$];
   int pwq[$];
   int prq[$];
   int cyc_cnt = 0, rise_cyc = 0, done_cyc = 0;
   int kl_cnt, ex_cnt, l0rd_cnt, l0wr_cnt, ofrd_cnt, done_cnt;
   int pair_err, fixed_err, ofv_err, relu_err, idle_err, sfp_err;
   logic prev_rd = 1'b0;
   logic prev_busy = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_rec();
      xq = {}; pwq = {}; prq = {};
      kl_cnt = 0; ex_cnt = 0; l0rd_cnt = 0; l0wr_cnt = 0; ofrd_cnt = 0; done_cnt = 0;
      pair_err = 0; fixed_err = 0; ofv_err = 0; relu_err = 0; idle_err = 0; sfp_err = 0;
   endtask

   // o_valid driver
   initial forever begin
      @(posedge clk);
      #1;
      case (ov_mode)
         0:       o_valid = 1'b1;
         1:       o_valid = ~o_valid;
         default: o_valid = ($urandom_range(0, 2) != 0);
      endcase
   end

   // monitor: records SRAM traffic and per-cycle rule violations
   initial forever begin
      @(negedge clk);
      cyc_cnt++;
      if (reset) begin
         if (busy && !prev_busy) rise_cyc = cyc_cnt;
         prev_busy = busy;
         if (inst[2] !== prev_rd) pair_err++;
         prev_rd = !xmem_cen;
         if (inst[4] | inst[5]) fixed_err++;
         if (inst[6] && !o_valid) ofv_err++;
         if (busy && inst[8] !== exp_relu) relu_err++;
         if (!busy && (inst !== 9'd0 || xmem_cen !== 1'b1 || pmem_cen !== 1'b1 ||
                       pmem_wen !== 1'b1 || done !== 1'b0)) idle_err++;
`ifdef CORELET_CTRL_ACCUM_EN
         if (!pmem_cen && pmem_wen && !inst[7]) sfp_err++;
         if (inst[6] && inst[7]) sfp_err++;
`else
         if (inst[7]) sfp_err++;
`endif
         if (!xmem_cen) xq.push_back(int'(xmem_addr));
         if (!pmem_cen && !pmem_wen) pwq.push_back(int'(pmem_addr));
         if (!pmem_cen && pmem_wen) prq.push_back(int'(pmem_addr));
         if (inst[0]) kl_cnt++;
         if (inst[1]) ex_cnt++;
         if (inst[2]) l0wr_cnt++;
         if (inst[3]) l0rd_cnt++;
         if (inst[6]) ofrd_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc_cnt;
         end
      end else begin
         prev_rd = 1'b0;
         prev_busy = 1'b0;
      end
   end

   // compare the recorded traffic of one complete tile with the expected traffic
   task automatic check_streams(input string tag);
      int ex[$];
      int bad;
      ex = {};
      for (int k = 0; k < NKIJ; k++) begin
         for (int i = 0; i < ROW; i++) ex.push_back(NACT + k * ROW + i);
         for (int i = 0; i < NACT; i++) ex.push_back(i);
      end
      check({tag, " xmem_len"}, xq.size(), ex.size());
      bad = 0;
      for (int i = 0; i < ex.size() && i < xq.size(); i++) if (xq[i] != ex[i]) bad++;
      check({tag, " xmem_seq_bad"}, bad, 0);

      ex = {};
      for (int a = 0; a < NKIJ * NACT; a++) ex.push_back(a);
`ifdef CORELET_CTRL_ACCUM_EN
      for (int o = 0; o < NACT; o++) ex.push_back(NKIJ * NACT + o);
`endif
      check({tag, " pwr_len"}, pwq.size(), ex.size());
      bad = 0;
      for (int i = 0; i < ex.size() && i < pwq.size(); i++) if (pwq[i] != ex[i]) bad++;
      check({tag, " pwr_seq_bad"}, bad, 0);

      ex = {};
`ifdef CORELET_CTRL_ACCUM_EN
      for (int o = 0; o < NACT; o++)
         for (int k = 0; k < NKIJ; k++) ex.push_back(k * NACT + o);
`endif
      check({tag, " prd_len"}, prq.size(), ex.size());
      bad = 0;
      for (int i = 0; i < ex.size() && i < prq.size(); i++) if (prq[i] != ex[i]) bad++;
      check({tag, " prd_seq_bad"}, bad, 0);

      check({tag, " kernel_load_cnt"}, kl_cnt, ROW * NKIJ);
      check({tag, " execute_cnt"}, ex_cnt, NACT * NKIJ);
      check({tag, " l0_rd_cnt"}, l0rd_cnt, (ROW + NACT) * NKIJ);
      check({tag, " l0_wr_cnt"}, l0wr_cnt, (ROW + NACT) * NKIJ);
      check({tag, " ofifo_rd_cnt"}, ofrd_cnt, NACT * NKIJ);
      check({tag, " done_cnt"}, done_cnt, 1);
      check({tag, " l0_wr_pairing_err"}, pair_err, 0);
      check({tag, " ififo_err"}, fixed_err, 0);
      check({tag, " ofifo_without_valid"}, ofv_err, 0);
      check({tag, " relu_err"}, relu_err, 0);
      check({tag, " idle_err"}, idle_err, 0);
      check({tag, " sfp_sel_err"}, sfp_err, 0);
   endtask

   // call just after a rising edge; returns just after the edge that enters the tile
   task automatic pulse_start(input logic rl);
      exp_relu = rl;
      relu_en = rl;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      relu_en = ~rl;
   endtask

   // returns at the falling edge of the done cycle
   task automatic wait_done(input string tag, input int bound);
      int seen = 0;
      for (int i = 0; i < bound && seen == 0; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1;
      end
      check({tag, " done_seen"}, seen, 1);
   endtask

   task automatic wait_xread(input string tag, input int addr, input int bound);
      int seen = 0;
      for (int i = 0; i < bound && seen == 0; i++) begin
         @(negedge clk);
         if (xmem_cen === 1'b0 && xmem_addr == 11'(addr)) seen = 1;
      end
      check({tag, " xread_seen"}, seen, 1);
   endtask

   initial begin
      int wait_bad;
      logic exec_seen;
      logic rl;
      int seen;

      // reset state
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst inst", inst, 0);
      check("rst xmem_cen", xmem_cen, 1);
      check("rst pmem_cen", pmem_cen, 1);
      check("rst pmem_wen", pmem_wen, 1);
      check("rst xmem_addr", xmem_addr, 0);
      check("rst pmem_addr", pmem_addr, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // tile A: relu on, o_valid held high, exact timing
      ov_mode = 0;
      clear_rec();
      @(posedge clk);
      #1;
      pulse_start(1'b1);
      for (int i = 0; i <= ROW; i++) begin
         @(negedge clk);
         if (i < ROW) begin
            check("A wload addr", xmem_addr, NACT + i);
            check("A wload cen", xmem_cen, 0);
         end else begin
            check("A wload cen_end", xmem_cen, 1);
         end
         check("A wload l0_wr", inst[2], (i > 0));
         check("A relu", inst[8], 1);
      end
      wait_done("A", 3000);
      check("A tile_len", done_cyc - rise_cyc, TILE_LEN);
      @(negedge clk);
      check("A busy_after_done", busy, 0);
      check_streams("A");

      // tile B: o_valid toggling, OFIFO back-pressure before EXEC, start during done
      ov_mode = 1;
      rl = 1'($urandom_range(0, 1));
      clear_rec();
      @(posedge clk);
      #1;
      pulse_start(rl);
      wait_xread("B", NACT - 1, 500);
      @(posedge clk);
      #1;
      o_ready = 1'b0;
      wait_bad = 0;
      exec_seen = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         if (i == 6) o_ready = 1'b1;
         @(negedge clk);
         if (i == 1) check("B aload last l0_wr", inst[2], 1);
         if (i <= 6 && (inst[3] || inst[1])) wait_bad++;
         if (i == 7) exec_seen = inst[1];
         if (i < 7) begin
            @(posedge clk);
            #1;
         end
      end
      check("B l0_rd_during_wait", wait_bad, 0);
      check("B exec_after_5_wait", exec_seen, 1);
      wait_done("B", 6000);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("B start_on_done_ignored", busy, 0);
      repeat (2) @(negedge clk);
      check("B still_idle", busy, 0);
      check_streams("B");

      // tile C: random o_valid, reset during EXEC of kij=4, then a fresh tile
      ov_mode = 2;
      rl = 1'($urandom_range(0, 1));
      clear_rec();
      @(posedge clk);
      #1;
      pulse_start(rl);
      wait_xread("C", NACT + 4 * ROW, 5000);
      seen = 0;
      for (int i = 0; i < 200 && seen == 0; i++) begin
         @(negedge clk);
         if (inst[1] === 1'b1) seen = 1;
      end
      check("C exec_kij4_seen", seen, 1);
      repeat ($urandom_range(1, 10)) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("C async busy", busy, 0);
      check("C async inst", inst, 0);
      check("C async xmem_cen", xmem_cen, 1);
      check("C async pmem_cen", pmem_cen, 1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("C no_done_after_abort", done_cnt, 0);
      check("C idle_after_abort", busy, 0);

      rl = 1'($urandom_range(0, 1));
      clear_rec();
      @(posedge clk);
      #1;
      pulse_start(rl);
      @(negedge clk);
      check("C restart kij0 addr", xmem_addr, NACT);
      // a start while busy must not disturb the tile
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("C", 8000);
      check_streams("C");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/corelet_ctrl.md
CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 SHALL have parameter row, default 8: L0 rows, equal to the weight vectors per kernel position.
REQ-002 SHALL have parameter col, default 8: MAC array columns.
REQ-003 SHALL have parameter nkij, default 9: kernel positions per tile.
REQ-004 SHALL have parameter nact, default 36: activation vectors per kernel position.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low (reset==0 forces reset state immediately).
REQ-007 SHALL have port start, input, 1: one-cycle pulse that launches a tile; ignored while busy=1.
REQ-008 SHALL have port relu_en, input, 1: sampled on start; drives inst[8] for the whole tile.
REQ-009 SHALL have port o_valid, input, 1: corelet OFIFO has a readable row.
REQ-010 SHALL have port o_ready, input, 1: corelet OFIFO can accept a row.
REQ-011 SHALL have port inst, output, 9: corelet instruction; bits {relu, sfp_sel, ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, kernel_load} from bit 8 down to bit 0.
REQ-012 SHALL have port xmem_addr, output, 11: activation/weight SRAM address.
REQ-013 SHALL have port xmem_cen, output, 1: active-low SRAM chip enable; SRAM read data is valid 1 cycle later.
REQ-014 SHALL have port pmem_addr, output, 11: psum SRAM address.
REQ-015 SHALL have port pmem_wen, output, 1: active-low psum write enable.
REQ-016 SHALL have port pmem_cen, output, 1: active-low psum chip enable.
REQ-017 SHALL have outputs busy, 1 bit, and done, 1 bit; done is a one-cycle pulse at tile end.

Function
REQ-018 SHALL implement the FSM IDLE->W_LOAD->K_LOAD->K_WAIT->A_LOAD->EXEC->DRAIN, then either back to W_LOAD (kij<nkij-1) or onward (last kij) to ACCUM (if compiled in) or DONE->IDLE.
REQ-019 W_LOAD SHALL read row words at xmem_addr = nact + kij*row + i, asserting xmem_cen=0; l0_wr=1 SHALL follow each read by exactly 1 cycle, so the state lasts row+1 cycles.
REQ-020 K_LOAD SHALL assert l0_rd=1 and kernel_load=1 for exactly row cycles; K_WAIT SHALL drive inst=0 (except relu) for col cycles.
REQ-021 A_LOAD SHALL read xmem_addr 0..nact-1, with l0_wr delayed by 1 cycle as in W_LOAD, lasting nact+1 cycles.
REQ-022 EXEC SHALL be entered only while o_ready=1 (otherwise it holds with l0_rd=0), then assert l0_rd=1 and execute=1 for nact cycles.
REQ-023 DRAIN SHALL assert ofifo_rd=1 only in cycles with o_valid=1, and in the same cycle SHALL drive pmem_cen=0, pmem_wen=0, pmem_addr = kij*nact + n; it SHALL exit after nact reads and stall indefinitely while o_valid=0.
REQ-024 ififo_wr and ififo_rd SHALL always be 0; sfp_sel SHALL be 0 outside ACCUM.
REQ-025 The kij counter SHALL wrap to 0 only on tile completion; busy SHALL be 1 in every state except IDLE.
REQ-026 A start pulse arriving in the same cycle as done SHALL be ignored.

Reset
REQ-027 On reset==0: state=IDLE, all counters 0, inst=0, xmem_cen=1, pmem_cen=1, pmem_wen=1, addresses 0, busy=0, done=0; a reset asserted mid-tile SHALL abort the tile with no done pulse.

Configuration
REQ-028 Macro CORELET_CTRL_ACCUM_EN: when defined, ACCUM runs after the last DRAIN. For each o in 0..nact-1 it reads pmem at k*nact+o for k=0..nkij-1 (pmem_cen=0, pmem_wen=1) with sfp_sel=1, then spends one write cycle at pmem_addr = nkij*nact+o; ACCUM therefore lasts nact*(nkij+1) cycles. When the macro is undefined, ACCUM is absent, sfp_sel is tied to 0, and the last DRAIN goes to DONE.

Verification
REQ-029 Reset, then start with relu_en=1 and o_valid held 1 -> W_LOAD issues xmem_addr 36..43, the first l0_wr occurs 1 cycle after the first read, and inst[8]=1 for the whole tile.
REQ-030 Full tile, macro off, o_valid=1 -> 9 DRAINs of 36 pmem writes each at addresses 0..323, one done pulse, busy=0 the next cycle.
REQ-031 o_ready=0 for 5 cycles at the end of A_LOAD -> entry to EXEC is delayed exactly 5 cycles, with no l0_rd during the wait.
REQ-032 o_valid toggled 1/0 every cycle during DRAIN -> exactly 36 ofifo_rd pulses, each coincident with o_valid=1, and pmem addresses contiguous.
REQ-033 reset pulled to 0 during EXEC of kij=4, then released and start issued -> the new tile restarts at kij=0 with no done pulse from the aborted tile.
REQ-034 Macro on -> ACCUM for o=0 reads addresses 0,36,...,288 with sfp_sel=1 and then writes address 324; ACCUM totals 360 cycles before done.
